// File: rtl/popcount_seq.sv
// Sequential population counter: one 7-bit chunk per cycle through a shared 7:3 carry-save counter.
// Optional build macro POPCOUNT_SKIP_ZERO_EN ends counting early once the remaining chunks are all zero.

module popcount_csa73 (
    input  logic [6:0] bits,
    output logic [2:0] cnt
);
    logic s0, c0, s1, c1, c2;

    // Two first-level full adders, then one on the sums and one on the carries.
    assign s0 = bits[0] ^ bits[1] ^ bits[2];
    assign c0 = (bits[0] & bits[1]) | (bits[0] & bits[2]) | (bits[1] & bits[2]);
    assign s1 = bits[3] ^ bits[4] ^ bits[5];
    assign c1 = (bits[3] & bits[4]) | (bits[3] & bits[5]) | (bits[4] & bits[5]);
    assign cnt[0] = s0 ^ s1 ^ bits[6];
    assign c2 = (s0 & s1) | (s0 & bits[6]) | (s1 & bits[6]);
    assign cnt[1] = c0 ^ c1 ^ c2;
    assign cnt[2] = (c0 & c1) | (c0 & c2) | (c1 & c2);
endmodule

module popcount_seq #(
    parameter int DATA_W = 28
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DATA_W+1)-1:0] out_count,
    output logic                        busy
);
    localparam int NCH = (DATA_W + 6) / 7;
    localparam int SW  = NCH * 7;
    localparam int CW  = $clog2(DATA_W + 1);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW  = (CW > 3) ? CW : 3;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sh_q, sh_d, sh_shift;
    logic [CW-1:0] acc_q, acc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic [2:0]    cnt3;
    logic [AW-1:0] sum_w;
    logic          last_chunk;

    popcount_csa73 u_csa (
        .bits (sh_q[6:0]),
        .cnt  (cnt3)
    );

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        sh_shift    = sh_q >> 7;
        sum_w       = AW'(acc_q) + AW'(cnt3);
`ifdef POPCOUNT_SKIP_ZERO_EN
        last_chunk  = (sh_shift == '0) || (idx_q == IW'(NCH - 1));
`else
        last_chunk  = (idx_q == IW'(NCH - 1));
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    sh_d              = '0;
                    sh_d[DATA_W-1:0]  = in_data;
                    acc_d             = '0;
                    idx_d             = '0;
                    state_d           = S_COUNT;
                end
            end
            S_COUNT: begin
                acc_d = sum_w[CW-1:0];
                sh_d  = sh_shift;
                idx_d = idx_q + IW'(1);
                if (last_chunk) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sh_q        <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_count = acc_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_popcount_seq.sv
// Bench for popcount_seq: scoreboarded directed steps, random traffic, and 30-bit / 1-bit instances.
// Expected latencies follow the POPCOUNT_SKIP_ZERO_EN build setting.

module tb_popcount_seq;
    localparam int NCH = 4;

    typedef struct {
        int cnt;
        int lat;
        int cyc;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_count;
    logic        busy;

    logic        v30, r30, ov30, b30;
    logic [29:0] d30;
    logic [4:0]  c30;
    logic        v1, r1, ov1, b1;
    logic [0:0]  d1;
    logic [0:0]  c1;
    logic        ordy_small;

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     last_acc = 0;
    bit     rand_or = 0;
    bit     prev_ov = 0;
    entry_t sb[$];

    popcount_seq #(.DATA_W(28)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .busy(busy)
    );

    popcount_seq #(.DATA_W(30)) dut30 (
        .clk(clk), .rst_n(rst_n), .in_valid(v30), .in_ready(r30),
        .in_data(d30), .out_valid(ov30), .out_ready(ordy_small),
        .out_count(c30), .busy(b30)
    );

    popcount_seq #(.DATA_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
        .in_data(d1), .out_valid(ov1), .out_ready(ordy_small),
        .out_count(c1), .busy(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endfunction

    function automatic int popc(input logic [27:0] w);
        int n = 0;
        for (int i = 0; i < 28; i++) n += int'(w[i]);
        return n;
    endfunction

    function automatic int lat_model(input logic [27:0] w);
`ifdef POPCOUNT_SKIP_ZERO_EN
        int k = 1;
        for (int c = 0; c < NCH; c++) begin
            if (((w >> (7 * c)) & 28'h7F) != 0) k = c + 1;
        end
        return k;
`else
        return (w == w) ? NCH : NCH;
`endif
    endfunction

    // Scoreboard monitor: pushes at input handshakes, checks and pops at output handshakes.
    always @(negedge clk) begin
        entry_t e;
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                e.cnt = popc(in_data);
                e.lat = lat_model(in_data);
                e.cyc = cyc + 1;
                last_acc = cyc + 1;
                sb.push_back(e);
            end
            if (out_valid) begin
                check("ready_low_in_done", in_ready, 0);
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    if (!prev_ov) check("latency", cyc - sb[0].cyc, sb[0].lat);
                    check("count", out_count, sb[0].cnt);
                    if (out_ready) void'(sb.pop_front());
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic [27:0] w);
        int t = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) check("send_timeout", t, 0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int c0;
        int l30, l1;
        logic [4:0] k30;
        logic [0:0] k1;
        logic [27:0] w;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        v30 = 1'b0; d30 = '0; v1 = 1'b0; d1 = '0; ordy_small = 1'b1;
        tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);

        // All ones, then back-to-back zero word: accept-to-accept spacing is latency + 2.
        out_ready = 1'b1;
        send(28'h0FFFFFFF);
        c0 = last_acc;
        check("busy_counting", busy, 1);
        send(28'h0000000);
        check("period", last_acc - c0, lat_model(28'h0FFFFFFF) + 2);
        send(28'h000007F);
        drain();

        // Backpressure with in_valid driven throughout the held result.
        out_ready = 1'b0;
        send(28'h5555555);
        in_valid = 1'b1;
        in_data  = 28'h0FFFFFF;
        c0 = 0;
        while (!out_valid && c0 < 50) begin tick(); c0++; end
        check("bp_out_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) tick();
        check("bp_held_count", out_count, 14);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_single_handshake", sb.size(), 0);
        check("bp_out_valid_drop", out_valid, 0);

        // Reset while counting discards the word.
        send(28'h0FFFFFFF);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        send(28'h0000003);
        drain();

        // Padded widths: 30-bit and 1-bit instances.
        check("rdy30", r30, 1);
        check("rdy1", r1, 1);
        v30 = 1'b1; d30 = 30'h3FFFFFFF; v1 = 1'b1; d1 = 1'b1;
        tick();
        v30 = 1'b0; v1 = 1'b0;
        l30 = 0; l1 = 0; k30 = '0; k1 = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ov30 && l30 == 0) begin l30 = i; k30 = c30; end
            if (ov1 && l1 == 0) begin l1 = i; k1 = c1; end
        end
        check("w30_count", k30, 30);
        check("w30_latency", l30, 5);
        check("w1_count", k1, 1);
        check("w1_latency", l1, 1);

        // Random traffic with random input gaps and output backpressure.
        rand_or = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            w = 28'($urandom);
            case ($urandom_range(0, 4))
                0: w = w & 28'h000007F;
                1: w = w & 28'h0003FFF;
                2: w = '0;
                default: ;
            endcase
            send(w);
        end
        rand_or = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
